// File: rtl/clock_core.sv
// clock_core: HH:MM digital clock with two debounced set buttons (mode, inc).
// Build option: define CLOCK_12H_EN for a 12-hour display with a PM flag on dd[3];
// the internal hour always runs 0..23.
`timescale 1ns/1ps
module clock_core #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] dd,
    output logic       sa,
    output logic       sb,
    output logic       sc,
    output logic       sd,
    output logic       sec_pulse
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

`ifdef CLOCK_12H_EN
    localparam logic [3:0] RST_A = 4'd1;
    localparam logic [3:0] RST_B = 4'd2;
`else
    localparam logic [3:0] RST_A = 4'd0;
    localparam logic [3:0] RST_B = 4'd0;
`endif

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Index 0 = mode button, index 1 = inc button.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_prev;
    logic [DW-1:0]   r_db_cnt [2];

    logic [PW-1:0]   r_presc;
    logic [5:0]      r_sec;
    logic [5:0]      r_min;
    logic [4:0]      r_hour;

    logic            w_ev_mode;
    logic            w_ev_inc;
    logic            w_run_cnt;
    logic            w_wrap;
    logic [PW-1:0]   w_presc_next;
    logic            w_colon;
    logic [4:0]      w_disp_hour;
    logic            w_pm;
    logic [7:0]      w_hour_bcd;
    logic [7:0]      w_min_bcd;

    // Binary 0..59 to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // Synchronize both buttons, then accept a new level after DEBOUNCE_CYCLES equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 2'b00;
            r_sync2   <= 2'b00;
            r_db      <= 2'b00;
            r_db_prev <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= {btn_inc, btn_mode};
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level is the press event; mode beats inc.
    assign w_ev_mode = r_db[0] & ~r_db_prev[0];
    assign w_ev_inc  = r_db[1] & ~r_db_prev[1] & ~w_ev_mode;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mode event cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
    always_comb begin
        w_state_next = r_state;
        if (w_ev_mode) begin
            case (r_state)
                ST_RUN:      w_state_next = ST_SET_HOUR;
                ST_SET_HOUR: w_state_next = ST_SET_MIN;
                default:     w_state_next = ST_RUN;
            endcase
        end
    end

    // Counting only happens while staying in RUN; any other case parks the prescaler at 0.
    assign w_run_cnt    = (r_state == ST_RUN) && (w_state_next == ST_RUN);
    assign w_wrap       = w_run_cnt && (r_presc == PRESC_MAX);
    assign w_presc_next = (w_run_cnt && !w_wrap) ? (r_presc + PW'(1)) : '0;
    assign w_colon      = !w_run_cnt || (w_presc_next < PRESC_HALF);

    // Prescaler and time-of-day counters, including set-mode increments.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_sec   <= 6'd0;
            r_min   <= 6'd0;
            r_hour  <= 5'd0;
        end else begin
            r_presc <= w_presc_next;
            if (w_wrap) begin
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    if (r_min == 6'd59) begin
                        r_min  <= 6'd0;
                        r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end else if (!w_run_cnt) begin
                r_sec <= 6'd0;
                if (w_ev_inc && (r_state == ST_SET_HOUR)) begin
                    r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                end
                if (w_ev_inc && (r_state == ST_SET_MIN)) begin
                    r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                end
            end
        end
    end

    // Displayed hour and PM flag for the selected format.
    always_comb begin
        w_disp_hour = r_hour;
        w_pm        = 1'b0;
`ifdef CLOCK_12H_EN
        w_pm = (r_hour >= 5'd12);
        if (r_hour == 5'd0) begin
            w_disp_hour = 5'd12;
        end else if (r_hour > 5'd12) begin
            w_disp_hour = r_hour - 5'd12;
        end
`endif
        w_hour_bcd = to_bcd(6'(w_disp_hour));
        w_min_bcd  = to_bcd(r_min);
    end

    // Registered display, point, blink and second-pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= RST_A;
            b         <= RST_B;
            c         <= 4'd0;
            d         <= 4'd0;
            dd        <= 4'b0010;
            sa        <= 1'b0;
            sb        <= 1'b0;
            sc        <= 1'b0;
            sd        <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            a         <= w_hour_bcd[7:4];
            b         <= w_hour_bcd[3:0];
            c         <= w_min_bcd[7:4];
            d         <= w_min_bcd[3:0];
            dd        <= {w_pm, 1'b0, w_colon, 1'b0};
            sa        <= (r_state == ST_SET_HOUR);
            sb        <= (r_state == ST_SET_HOUR);
            sc        <= (r_state == ST_SET_MIN);
            sd        <= (r_state == ST_SET_MIN);
            sec_pulse <= w_wrap;
        end
    end

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: randomized self-checking bench for clock_core against a time-of-day model.
`timescale 1ns/1ps
module tb_clock_core;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    // Raw press to state change: two sync flops, DEB debounce samples, edge detect.
    localparam int EV_LAT = 3 + DEB;
    localparam int REL    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] a, b, c, d, dd;
    logic       sa, sb, sc, sd, sec_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0=RUN 1=SET_HOUR 2=SET_MIN; in RUN time = m_base + elapsed seconds.
    int m_mode, m_hour, m_min, m_base, m_j;

    clock_core #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .a(a), .b(b), .c(c), .d(d), .dd(dd),
        .sa(sa), .sb(sb), .sc(sc), .sd(sd), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] obs_vec();
        return {a, b, c, d, dd, sa, sb, sc, sd, sec_pulse};
    endfunction

    function automatic logic [24:0] exp_vec();
        int t, hh, mm, dh;
        logic colon, pulse, pm;
        logic [3:0] blink;
        if (m_mode == 0) begin
            t     = (m_base + ((m_j > 0) ? (m_j - 1) / CLK_HZ : 0)) % 86400;
            hh    = t / 3600;
            mm    = (t / 60) % 60;
            colon = (m_j % CLK_HZ) < (CLK_HZ / 2);
            pulse = (m_j > 0) && (m_j % CLK_HZ == 0);
            blink = 4'b0000;
        end else begin
            hh    = m_hour;
            mm    = m_min;
            colon = 1'b1;
            pulse = 1'b0;
            blink = (m_mode == 1) ? 4'b1100 : 4'b0011;
        end
`ifdef CLOCK_12H_EN
        dh = (hh % 12 == 0) ? 12 : hh % 12;
        pm = (hh >= 12);
`else
        dh = hh;
        pm = 1'b0;
`endif
        return {4'(dh / 10), 4'(dh % 10), 4'(mm / 10), 4'(mm % 10),
                pm, 1'b0, colon, 1'b0, blink, pulse};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hour = 0; m_min = 0; m_base = 0; m_j = 0;
    endtask

    // Drive a press for 'hold' cycles, release, and apply its effect to the model.
    task automatic press(input logic pm, input logic pi, input int hold);
        int j_e, n, t;
        j_e = m_j;
        btn_mode = pm;
        btn_inc  = pi;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (REL) @(posedge clk);
        #1;
        n = hold + REL;
        if (hold >= DEB && pm) begin
            if (m_mode == 0) begin
                t = (m_base + (j_e + EV_LAT - 1) / CLK_HZ) % 86400;
                m_hour = t / 3600;
                m_min  = (t / 60) % 60;
                m_mode = 1;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0;
                m_base = m_hour * 3600 + m_min * 60;
                m_j    = n - EV_LAT;
            end
        end else begin
            if (hold >= DEB && pi && m_mode == 1) m_hour = (m_hour + 1) % 24;
            else if (hold >= DEB && pi && m_mode == 2) m_min = (m_min + 1) % 60;
            if (m_mode == 0) m_j += n;
        end
    endtask

    task automatic set_time(input int h, input int mi);
        press(1'b1, 1'b0, 8);
        repeat ((h - m_hour + 24) % 24) press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
        repeat ((mi - m_min + 60) % 60) press(1'b0, 1'b1, 8);
        press(1'b1, 1'b0, 8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_first_second();
        int pulses;
        pulses = 0;
        repeat (CLK_HZ) begin
            @(posedge clk); #1; m_j++;
            if (sec_pulse) pulses++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL first_second j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL first_second_pulses got=%0d exp=1", pulses);
        else n_pass++;
    endtask

    task automatic test_set_fields();
        int first;
        first = -1;
        press(1'b1, 1'b0, 8);
        repeat (25) press(1'b0, 1'b1, 8);
        n_checks++;
        if (obs_vec() !== exp_vec() || {sa, sb, sc, sd} !== 4'b1100)
            $display("FAIL set_hour_25 got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b1, 1'b0, 8);
        repeat (61) press(1'b0, 1'b1, 8);
        n_checks++;
        if (obs_vec() !== exp_vec() || {sa, sb, sc, sd} !== 4'b0011)
            $display("FAIL set_min_61 got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b1, 1'b0, 8);
        while (m_j < CLK_HZ + 3) begin
            @(posedge clk); #1; m_j++;
            if (sec_pulse && first < 0) first = m_j;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL run_entry j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (first !== CLK_HZ) $display("FAIL first_pulse_after_entry got=%0d exp=%0d", first, CLK_HZ);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1, 8);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL simult_run got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b1, 1'b1, 8);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL simult_set_hour got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b1, 1'b0, 8);
        repeat (15) begin
            @(posedge clk); #1; m_j++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL simult_back_run j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int h0;
        press(1'b1, 1'b0, 8);
        h0 = m_hour;
        press(1'b0, 1'b1, 3);
        n_checks++;
        if (obs_vec() !== exp_vec() || m_hour !== h0) $display("FAIL glitch_3 got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b0, 1'b1, 20);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL hold_20 got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
    endtask

    task automatic test_rollover();
        int pulses;
        pulses = 0;
        set_time(23, 59);
        while (m_j < 60 * CLK_HZ + 5) begin
            @(posedge clk); #1; m_j++;
            if (sec_pulse) pulses++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rollover j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({a, b, c, d} !== exp_vec()[24:9]) $display("FAIL rollover_final got=%h exp=%h", {a, b, c, d}, exp_vec()[24:9]);
        else n_pass++;
    endtask

    task automatic test_12h();
        logic [8:0] exp_lit;
        press(1'b1, 1'b0, 8);
        repeat ((13 - m_hour + 24) % 24) press(1'b0, 1'b1, 8);
`ifdef CLOCK_12H_EN
        exp_lit = {4'd0, 4'd1, 1'b1};
`else
        exp_lit = {4'd1, 4'd3, 1'b0};
`endif
        n_checks++;
        if ({a, b, dd[3]} !== exp_lit || obs_vec() !== exp_vec())
            $display("FAIL hour13 got=%h exp=%h", {a, b, dd[3]}, exp_lit);
        else n_pass++;
        repeat (11) press(1'b0, 1'b1, 8);
`ifdef CLOCK_12H_EN
        exp_lit = {4'd1, 4'd2, 1'b0};
`else
        exp_lit = {4'd0, 4'd0, 1'b0};
`endif
        n_checks++;
        if ({a, b, dd[3]} !== exp_lit || obs_vec() !== exp_vec())
            $display("FAIL hour0 got=%h exp=%h", {a, b, dd[3]}, exp_lit);
        else n_pass++;
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
    endtask

    task automatic test_random();
        int cyc;
        repeat (4) begin
            set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            cyc = int'($urandom_range(20, 300));
            repeat (cyc) begin
                @(posedge clk); #1; m_j++;
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL random_run j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
                else n_pass++;
            end
            press(1'b0, 1'b1, int'($urandom_range(1, 10)));
            press(1'b1, 1'b0, int'($urandom_range(1, 3)));
            repeat (20) begin
                @(posedge clk); #1; m_j++;
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL random_after_ignored j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (7) begin @(posedge clk); #1; m_j++; end
        btn_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; btn_mode = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_mid_run got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        repeat (12) begin
            @(posedge clk); #1; m_j++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL after_reset_mid j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        btn_inc = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; btn_inc = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_mid_set got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        repeat (12) begin
            @(posedge clk); #1; m_j++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL after_reset_set j=%0d got=%h exp=%h", m_j, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_second();
        test_set_fields();
        test_simultaneous();
        test_glitch();
        test_rollover();
        test_12h();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_core.md
CLOCK_CORE -- requirements
Module: clock_core

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk cycles per second (even, >=4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before a button level is accepted (>=1).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_mode  input  1  raw asynchronous button, active-high: advance set mode.
REQ-006 btn_inc  input  1  raw asynchronous button, active-high: increment selected field.
REQ-007 a  output  4  BCD hour tens; b  output  4  BCD hour units.
REQ-008 c  output  4  BCD minute tens; d  output  4  BCD minute units.
REQ-009 dd  output  4  decimal-point enables, bit i for digit i (0=a), 1 = point lit.
REQ-010 sa, sb, sc, sd  output  1 each  blink request per digit, 1 = digit blinks.
REQ-011 sec_pulse  output  1  one-cycle pulse at each elapsed second in RUN.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-013 A press event SHALL be one cycle on the debounced 0->1 edge; release generates nothing; holding generates one event only.
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 and wrap; sec_pulse SHALL assert in the cycle it wraps, in RUN only.
REQ-015 Time state: sec 0..59, min 0..59, hour 0..23, binary internally; outputs SHALL be registered BCD conversions, updated one cycle after the state change.
REQ-016 On sec_pulse: sec+1; 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0; 23:59:59 -> 00:00:00 in one step.
REQ-017 FSM states RUN, SET_HOUR, SET_MIN; mode event: RUN->SET_HOUR->SET_MIN->RUN.
REQ-018 In SET_HOUR and SET_MIN, prescaler and sec SHALL be held at 0, no carries occur, sec_pulse stays 0.
REQ-019 Inc event in SET_HOUR: hour = (hour+1) mod 24, min unchanged; in SET_MIN: min = (min+1) mod 60, no carry into hour; in RUN: ignored.
REQ-020 Simultaneous mode and inc events in the same cycle: mode SHALL win, inc discarded.
REQ-021 Entering RUN from SET_MIN SHALL restart counting with prescaler=0, sec=0; first sec_pulse CLK_HZ cycles later.
REQ-022 sa=sb=1 only in SET_HOUR; sc=sd=1 only in SET_MIN; all 0 in RUN.
REQ-023 dd[1] (colon) SHALL be 1 while prescaler < CLK_HZ/2 and 0 otherwise in RUN, steady 1 in set states; dd[0]=dd[2]=0 always.
REQ-024 dd[3] SHALL be 0 unless defined otherwise by REQ-029.

Reset
REQ-025 rst SHALL force state RUN, hour=min=sec=0, prescaler=0, debouncers and synchronizers to 0 (released), pending events cleared.
REQ-026 Outputs after rst: a=b=c=d=0, dd=4'b0010, sa=sb=sc=sd=0, sec_pulse=0.
REQ-027 rst mid-operation (any state, mid-debounce, mid-second) SHALL take effect the next edge with no event or carry emitted that cycle.

Configuration
REQ-028 Macro CLOCK_12H_EN selects display format; internal hour remains 0..23 in all builds.
REQ-029 With CLOCK_12H_EN defined: displayed hour = 12 if hour mod 12 = 0, else hour mod 12; dd[3]=1 when hour>=12 (PM); reset displays 12:00, dd=4'b0010.
REQ-030 Without CLOCK_12H_EN: displayed hour = hour (00..23), dd[3]=0.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-031 rst, run 10 cycles -> sec_pulse once at cycle 10; dd[1] 1 for cycles 0-4, 0 for 5-9; a..d = 0,0,0,0.
REQ-032 Preset 23:59:59 via set mode and run-out, one sec_pulse -> a..d = 0,0,0,0, sec=0 same step.
REQ-033 btn_inc glitch high 3 cycles -> no event; held 20 cycles -> exactly one event.
REQ-034 Mode press, 25 inc presses -> SET_HOUR, hour 01, sa=sb=1; mode, 61 inc -> SET_MIN, min 01, sc=sd=1, hour 01; mode -> RUN, first sec_pulse 10 cycles after entry.
REQ-035 Mode and inc pressed in the same cycle in RUN -> SET_HOUR, hour unchanged.
REQ-036 CLOCK_12H_EN build, set hour 13 -> a,b = 0,1, dd[3]=1; hour 0 -> a,b = 1,2, dd[3]=0.
